// File: rtl/peripheral_bus_pkg.sv
// Shared definitions for the peripheral bus bridge.
//   bridge_state_t : FSM encoding (IDLE -> ACCESS -> RESP)
//   BUS_DATA_W     : bus/register data width
//   BUS_STRB_W     : number of byte-lane strobes
//   strb_merge()   : byte-lane merge of new write data over an old word
package peripheral_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bridge_state_t;

    localparam int BUS_DATA_W = 32;
    localparam int BUS_STRB_W = 4;

    // Lane i takes new_w when strb[i] is set, otherwise keeps old_w.
    function automatic logic [BUS_DATA_W-1:0] strb_merge(
        input logic [BUS_DATA_W-1:0] old_w,
        input logic [BUS_DATA_W-1:0] new_w,
        input logic [BUS_STRB_W-1:0] strb
    );
        logic [BUS_DATA_W-1:0] merged;
        for (int i = 0; i < BUS_STRB_W; i++) begin
            merged[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/peripheral_bus_decode.sv
// Combinational byte-address decoder for the bus bridge.
//   addr : byte address
//   idx  : register index (meaningful only when err == 0)
//   sel  : one-hot register select, all zero on error
//   err  : misaligned address or index beyond REGS-1
module peripheral_bus_decode
    import peripheral_bus_pkg::*;
#(
    parameter int REGS   = 3,
    parameter int ADDR_W = 8,
    localparam int IDX_W = (REGS > 1) ? $clog2(REGS) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic [REGS-1:0]   sel,
    output logic              err
);

    // One extra bit so REGS == 2**(ADDR_W-2) still compares correctly.
    localparam logic [ADDR_W-2:0] REGS_LIM = (ADDR_W-1)'(REGS);

    logic [ADDR_W-2:0] word_addr;

    always_comb begin
        word_addr = {1'b0, addr[ADDR_W-1:2]};
        err       = (addr[1:0] != 2'b00) || (word_addr >= REGS_LIM);
        idx       = addr[IDX_W+1:2];
        sel       = '0;
        if (!err) begin
            sel[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/peripheral_bus_bridge.sv
// Bus-slave bridge in front of the peripheral register block.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. Once
// rsp_valid is raised it and the response fields hold until that transfer.
//   clk, reset                  : clock, synchronous active-low reset
//   req_valid/req_ready         : request handshake
//   req_write/addr/wdata/wstrb  : request fields (sampled at acceptance only)
//   rsp_valid/rsp_ready         : response handshake
//   rsp_rdata, rsp_error        : response payload
//   reg_write_en, reg_data_in   : one-hot write pulse and merged data to core
//   reg_data_out                : flattened core read data, reg k at [32k+31:32k]
module peripheral_bus_bridge
    import peripheral_bus_pkg::*;
#(
    parameter int REGS   = 3,
    parameter int ADDR_W = 8,
    localparam int IDX_W = (REGS > 1) ? $clog2(REGS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [BUS_DATA_W-1:0]      req_wdata,
    input  logic [BUS_STRB_W-1:0]      req_wstrb,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [BUS_DATA_W-1:0]      rsp_rdata,
    output logic                       rsp_error,
    output logic [REGS-1:0]            reg_write_en,
    output logic [BUS_DATA_W-1:0]      reg_data_in,
    input  logic [REGS*BUS_DATA_W-1:0] reg_data_out
);

    bridge_state_t         state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [BUS_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;
    logic                  wr_q, wr_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [BUS_DATA_W-1:0] wdata_q, wdata_d;
    logic [BUS_STRB_W-1:0] wstrb_q, wstrb_d;

    logic [IDX_W-1:0]      dec_idx;
    logic [REGS-1:0]       dec_sel;
    logic                  dec_err;
    logic [BUS_DATA_W-1:0] cur_word;

    peripheral_bus_decode #(
        .REGS   (REGS),
        .ADDR_W (ADDR_W)
    ) u_decode (
        .addr (addr_q),
        .idx  (dec_idx),
        .sel  (dec_sel),
        .err  (dec_err)
    );

    // Current contents of the addressed register (used for reads and merges).
    always_comb begin
        cur_word = '0;
        for (int k = 0; k < REGS; k++) begin
            if (dec_idx == IDX_W'(k)) begin
                cur_word = reg_data_out[k*BUS_DATA_W +: BUS_DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rsp_valid_d = 1'b1;
                rsp_error_d = dec_err;
                rsp_rdata_d = (!wr_q && !dec_err) ? cur_word : '0;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered ready: low throughout reset, high from the first edge
        // after release, and high again on the edge that completes RESP.
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    // Write pulse exists only while the FSM sits in ACCESS; sel is already
    // all-zero on a decode error, so errored writes never pulse.
    always_comb begin
        reg_write_en = '0;
        reg_data_in  = '0;
        if (state_q == ACCESS && wr_q) begin
            reg_write_en = dec_sel;
            if (!dec_err) begin
                reg_data_in = strb_merge(cur_word, wdata_q, wstrb_q);
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule
